// File: rtl/rocc_cmd_issuer.sv
// Host-side issuer for the 160b cmd / 74b resp accelerator link: packs one custom instruction,
// issues it, optionally waits for the matching response and presents it as a writeback.
module rocc_cmd_issuer #(
  parameter int P_TIMEOUT   = 1024,
  parameter int P_CNT_NBITS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_vld,
  output logic                   req_rdy,
  input  logic [31:0]            req_inst,
  input  logic [63:0]            req_rs1_data,
  input  logic [63:0]            req_rs2_data,
  output logic [159:0]           cmd,
  output logic                   cmd_vld,
  input  logic                   cmd_rdy,
  input  logic [73:0]            resp,
  input  logic                   resp_vld,
  output logic                   resp_rdy,
  output logic                   wb_vld,
  input  logic                   wb_rdy,
  output logic [4:0]             wb_rd,
  output logic [63:0]            wb_data,
  output logic                   busy,
  input  logic                   err_clr,
  output logic                   err_timeout,
  output logic                   err_rd_mismatch,
  output logic                   err_stray,
  output logic [P_CNT_NBITS-1:0] cnt_issued,
  output logic [P_CNT_NBITS-1:0] cnt_retired
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_RESP, S_WB} state_t;

  localparam int TW = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(P_TIMEOUT - 1);

  state_t                 state_reg, state_next;
  logic [TW-1:0]          timer_reg, timer_next;
  logic [159:0]           cmd_reg, cmd_next;
  logic [4:0]             wb_rd_reg, wb_rd_next;
  logic [63:0]            wb_data_reg, wb_data_next;
  logic                   timeout_reg, mismatch_reg, stray_reg;
  logic [P_CNT_NBITS-1:0] issued_reg, retired_reg;

  logic req_go, cmd_go, resp_go, wb_go;
  logic timeout_evt, mismatch_evt, stray_evt, retire_evt;

  // Status bits of the response carry no meaning for the issuer.
  logic unused_resp_status;
  assign unused_resp_status = ^resp[4:0];

  assign req_rdy  = (state_reg == S_IDLE);
  assign cmd_vld  = (state_reg == S_SEND);
  assign resp_rdy = (state_reg == S_IDLE) || (state_reg == S_WAIT_RESP);
  assign wb_vld   = (state_reg == S_WB);
  assign busy     = (state_reg != S_IDLE);

  assign req_go  = req_vld && req_rdy;
  assign cmd_go  = cmd_vld && cmd_rdy;
  assign resp_go = resp_vld && resp_rdy;
  assign wb_go   = wb_vld && wb_rdy;

  assign cmd             = cmd_reg;
  assign wb_rd           = wb_rd_reg;
  assign wb_data         = wb_data_reg;
  assign err_timeout     = timeout_reg;
  assign err_rd_mismatch = mismatch_reg;
  assign err_stray       = stray_reg;
  assign cnt_issued      = issued_reg;
  assign cnt_retired     = retired_reg;

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    cmd_next     = cmd_reg;
    wb_rd_next   = wb_rd_reg;
    wb_data_next = wb_data_reg;
    timeout_evt  = 1'b0;
    mismatch_evt = 1'b0;
    stray_evt    = 1'b0;
    retire_evt   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        stray_evt = resp_go;
        if (req_go) begin
          cmd_next   = {req_rs2_data, req_rs1_data, req_inst};
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (cmd_go) begin
          // inst bit 17 is xd: only then does the accelerator answer.
          if (cmd_reg[17]) begin
            timer_next = '0;
            state_next = S_WAIT_RESP;
          end else begin
            retire_evt = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_WAIT_RESP: begin
        timer_next = timer_reg + 1'b1;
        if (resp_go) begin
          wb_rd_next   = resp[9:5];
          wb_data_next = resp[73:10];
          mismatch_evt = (resp[9:5] != cmd_reg[24:20]);
          state_next   = S_WB;
        end else if (timer_reg == TIMER_LAST) begin
          timeout_evt = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_WB: begin
        if (wb_go) begin
          retire_evt = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      cmd_reg      <= '0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
      timeout_reg  <= 1'b0;
      mismatch_reg <= 1'b0;
      stray_reg    <= 1'b0;
      issued_reg   <= '0;
      retired_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      cmd_reg      <= cmd_next;
      wb_rd_reg    <= wb_rd_next;
      wb_data_reg  <= wb_data_next;
      // A set event in the clearing cycle keeps the flag high.
      timeout_reg  <= timeout_evt  || (timeout_reg  && !err_clr);
      mismatch_reg <= mismatch_evt || (mismatch_reg && !err_clr);
      stray_reg    <= stray_evt    || (stray_reg    && !err_clr);
      if (cmd_go)     issued_reg  <= issued_reg + 1'b1;
      if (retire_evt) retired_reg <= retired_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// Randomized bench for rocc_cmd_issuer: a driver issues instructions and plays the accelerator,
// while a monitor checks every cmd and writeback handshake against queued expectations.
module tb_rocc_cmd_issuer;
  localparam int TO = 16;
  localparam int CN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_vld, req_rdy;
  logic [31:0]   req_inst;
  logic [63:0]   req_rs1_data, req_rs2_data;
  logic [159:0]  cmd;
  logic          cmd_vld, cmd_rdy;
  logic [73:0]   resp;
  logic          resp_vld, resp_rdy;
  logic          wb_vld, wb_rdy;
  logic [4:0]    wb_rd;
  logic [63:0]   wb_data;
  logic          busy, err_clr, err_timeout, err_rd_mismatch, err_stray;
  logic [CN-1:0] cnt_issued, cnt_retired;

  rocc_cmd_issuer #(.P_TIMEOUT(TO), .P_CNT_NBITS(CN)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_inst(req_inst),
    .req_rs1_data(req_rs1_data), .req_rs2_data(req_rs2_data),
    .cmd(cmd), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .resp(resp), .resp_vld(resp_vld), .resp_rdy(resp_rdy),
    .wb_vld(wb_vld), .wb_rdy(wb_rdy), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .err_clr(err_clr), .err_timeout(err_timeout),
    .err_rd_mismatch(err_rd_mismatch), .err_stray(err_stray),
    .cnt_issued(cnt_issued), .cnt_retired(cnt_retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [159:0] cmd_q[$];
  logic [68:0]  wb_q[$];

  // Reference model: counts and sticky flags derived from the transactions issued.
  int exp_issued, exp_retired;
  bit exp_to, exp_mm, exp_st;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [4:0] rd,
                                          input logic xd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [6:0] funct);
    return {op, rd, 1'b1, 1'b1, xd, rs1, rs2, funct};
  endfunction

  always @(negedge clk) begin
    if (!rst && cmd_vld && cmd_rdy) begin
      if (cmd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cmd_unexpected: cmd handshake %0h, expected none", cmd);
      end else check("cmd_payload", cmd, cmd_q.pop_front());
    end
    if (!rst && wb_vld && wb_rdy) begin
      if (wb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected: wb rd=%0d data=%0h, expected none", wb_rd, wb_data);
      end else check("wb_payload", {wb_rd, wb_data}, wb_q.pop_front());
    end
  end

  task automatic model_reset();
    exp_issued = 0; exp_retired = 0; exp_to = 0; exp_mm = 0; exp_st = 0;
  endtask

  task automatic check_state();
    check("cnt_issued", cnt_issued, exp_issued % (1 << CN));
    check("cnt_retired", cnt_retired, exp_retired % (1 << CN));
    check("err_timeout", err_timeout, exp_to);
    check("err_rd_mismatch", err_rd_mismatch, exp_mm);
    check("err_stray", err_stray, exp_st);
  endtask

  task automatic check_reset();
    check("rst_cmd_vld", cmd_vld, 0);
    check("rst_resp_rdy", resp_rdy, 1);
    check("rst_wb_vld", wb_vld, 0);
    check("rst_req_rdy", req_rdy, 1);
    check("rst_busy", busy, 0);
    check("rst_cmd", cmd, 0);
    check("rst_wb", {wb_rd, wb_data}, 0);
    check_state();
  endtask

  // mode 0: respond after resp_wait cycles; 1: never respond; 2: reset after resp_wait cycles
  task automatic issue(input logic [31:0] inst, input logic [63:0] a, input logic [63:0] b,
                       input int cmd_wait, input int mode, input int resp_wait,
                       input logic [4:0] rrd, input logic [63:0] rdata, input int wb_wait);
    logic [159:0] exp_cmd;
    exp_cmd = {b, a, inst};
    $display("txn inst=%08h xd=%0d mode=%0d cmd_wait=%0d resp_wait=%0d rrd=%0d wb_wait=%0d",
             inst, inst[17], mode, cmd_wait, resp_wait, rrd, wb_wait);
    check("req_rdy_idle", req_rdy, 1);
    req_vld = 1; req_inst = inst; req_rs1_data = a; req_rs2_data = b;
    cmd_q.push_back(exp_cmd);
    step();
    req_vld = 0; req_inst = $urandom; req_rs1_data = {$urandom, $urandom};
    check("cmd_vld_latency", cmd_vld, 1);
    check("req_rdy_send", req_rdy, 0);
    for (int i = 0; i < cmd_wait; i++) begin
      step();
      check("cmd_hold", cmd, exp_cmd);
      check("cmd_vld_hold", cmd_vld, 1);
      check("resp_rdy_send", resp_rdy, 0);
    end
    cmd_rdy = 1;
    step();
    cmd_rdy = 0;
    exp_issued++;
    if (!inst[17]) begin
      exp_retired++;
      check("req_rdy_after_cmd", req_rdy, 1);
      check("busy_after_cmd", busy, 0);
      check("wb_vld_xd0", wb_vld, 0);
    end else begin
      check("resp_rdy_wait", resp_rdy, 1);
      check("busy_wait", busy, 1);
      if (mode == 0) begin
        repeat (resp_wait) step();
        resp_vld = 1; resp = {rdata, rrd, 5'($urandom)};
        wb_q.push_back({rrd, rdata});
        if (rrd != inst[24:20]) exp_mm = 1;
        step();
        resp_vld = 0; resp = {$urandom, $urandom, $urandom};
        check("wb_vld_latency", wb_vld, 1);
        check("resp_rdy_wb", resp_rdy, 0);
        for (int i = 0; i < wb_wait; i++) begin
          step();
          check("wb_hold", {wb_vld, wb_rd, wb_data}, {1'b1, rrd, rdata});
        end
        wb_rdy = 1;
        step();
        wb_rdy = 0;
        exp_retired++;
        check("idle_after_wb", req_rdy, 1);
      end else if (mode == 1) begin
        repeat (TO - 1) step();
        check("busy_before_timeout", busy, 1);
        check("no_early_timeout", err_timeout, exp_to);
        step();
        exp_to = 1;
        check("timeout_to_idle", req_rdy, 1);
      end else begin
        repeat (resp_wait) step();
        rst = 1;
        step();
        rst = 0;
        model_reset();
        check_reset();
        return;
      end
    end
    check_state();
  endtask

  task automatic stray(input bit clr);
    check("req_rdy_stray", req_rdy, 1);
    resp_vld = 1; resp = {$urandom, $urandom, $urandom}; err_clr = clr;
    step();
    resp_vld = 0; err_clr = 0;
    if (clr) begin exp_to = 0; exp_mm = 0; end
    exp_st = 1;
    $display("txn stray resp clr=%0d", clr);
    check("stray_no_wb", wb_vld, 0);
    check_state();
  endtask

  task automatic clear_errs();
    err_clr = 1;
    step();
    err_clr = 0;
    exp_to = 0; exp_mm = 0; exp_st = 0;
    $display("txn err_clr");
    check_state();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] inst;
    int r, mode;
    logic [4:0] rrd;
    rst = 1; req_vld = 0; req_inst = 0; req_rs1_data = 0; req_rs2_data = 0;
    cmd_rdy = 0; resp = 0; resp_vld = 0; wb_rdy = 0; err_clr = 0;
    model_reset();
    repeat (3) step();
    rst = 0;
    check_reset();

    issue(mk_inst(7'h0B, 5'd3, 1'b1, 5'd1, 5'd2, 7'h1), 64'h5, 64'h7, 0, 0, 2, 5'd3, 64'd12, 0);
    issue(mk_inst(7'h0B, 5'd9, 1'b0, 5'd4, 5'd6, 7'h2), 64'hA5A5, 64'h5A5A, 5, 0, 0, 5'd0, 64'd0, 0);
    issue(mk_inst(7'h2B, 5'd7, 1'b1, 5'd1, 5'd2, 7'h3), 64'h1, 64'h2, 1, 1, 0, 5'd0, 64'd0, 0);
    clear_errs();
    issue(mk_inst(7'h0B, 5'd5, 1'b1, 5'd3, 5'd8, 7'h4), 64'h11, 64'h22, 0, 0, 0, 5'd6,
          64'hFFFF_FFFF_FFFF_FFFF, 3);
    stray(1'b0);
    clear_errs();
    issue(mk_inst(7'h0B, 5'd12, 1'b1, 5'd3, 5'd8, 7'h5), 64'h33, 64'h44, 0, 0, TO - 1, 5'd12,
          64'hDEAD_BEEF, 1);
    issue(mk_inst(7'h0B, 5'd2, 1'b1, 5'd3, 5'd8, 7'h6), 64'h55, 64'h66, 0, 2, 4, 5'd2, 64'h0, 0);
    issue(mk_inst(7'h0B, 5'd2, 1'b1, 5'd3, 5'd8, 7'h7), 64'h77, 64'h88, 0, 0, 1, 5'd2, 64'h99, 0);

    for (int t = 0; t < 40; t++) begin
      inst = $urandom;
      r = $urandom_range(0, 7);
      mode = (r == 0) ? 1 : 0;
      rrd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : inst[24:20];
      issue(inst, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3), mode,
            $urandom_range(0, TO - 1), rrd, {$urandom, $urandom}, $urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r == 0) stray(1'b0);
      else if (r == 1) stray(1'b1);
      else if (r == 2) clear_errs();
    end

    step();
    check("cmd_q_drained", cmd_q.size(), 0);
    check("wb_q_drained", wb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
